// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer: drives one inference through conv -> pool -> fc,
// tracks the argmax of the streamed FC class scores and reports the result.
// Every output is a register loaded from the next-state decode, so each
// output changes on the same edge as the state it belongs to.
module cnn_layer_sequencer #(
    parameter int SCORE_W     = 32,
    parameter int NUM_CLASSES = 10,
    parameter int TIMEOUT     = 65535
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [3:0]                label,
    output logic                      conv_start,
    input  logic                      conv_done,
    output logic                      pool_start,
    input  logic                      pool_done,
    output logic                      fc_start,
    input  logic                      score_valid,
    input  logic signed [SCORE_W-1:0] score_data,
    input  logic                      fc_done,
    output logic                      busy,
    output logic                      done,
    output logic [3:0]                classification,
    output logic                      correct,
    output logic                      err
);

    // The beat counter needs one extra value so that "all classes seen"
    // is representable even when NUM_CLASSES is 16.
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int KW = $clog2(NUM_CLASSES + 1);

    typedef enum logic [2:0] {
        IDLE, CONV, POOL, FC, FINISH, ERROR
    } state_t;

    state_t                     state, state_nxt;
    logic [TW-1:0]              timer;
    logic [KW-1:0]              beat_cnt;
    logic [KW-1:0]              beats_seen;
    logic signed [SCORE_W-1:0]  best_score, best_score_nxt;
    logic [3:0]                 best_idx, best_idx_nxt;
    logic [3:0]                 label_q;
    logic                       beat_take;
    logic                       timed_out;

    // Argmax update for this cycle's beat; a beat coinciding with fc_done
    // must still count, so the exit decision and the result use these values.
    always_comb begin
        beat_take      = (state == FC) && score_valid && (beat_cnt < KW'(NUM_CLASSES));
        best_score_nxt = best_score;
        best_idx_nxt   = best_idx;
        if (beat_take && ((beat_cnt == '0) || (score_data > best_score))) begin
            best_score_nxt = score_data;
            best_idx_nxt   = 4'(beat_cnt);
        end
        beats_seen = beat_cnt + KW'(beat_take);
        timed_out  = (timer == TW'(TIMEOUT - 1));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode; a stage's own done wins over a coincident timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (start) state_nxt = CONV;
            CONV:   if (conv_done) state_nxt = POOL;
                    else if (timed_out) state_nxt = ERROR;
            POOL:   if (pool_done) state_nxt = FC;
                    else if (timed_out) state_nxt = ERROR;
            FC:     if (fc_done) state_nxt = (beats_seen == KW'(NUM_CLASSES)) ? FINISH : ERROR;
                    else if (timed_out) state_nxt = ERROR;
            FINISH: state_nxt = IDLE;
            ERROR:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage timer, beat counter, label latch and running best score.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer      <= '0;
            beat_cnt   <= '0;
            best_score <= '0;
            best_idx   <= '0;
            label_q    <= '0;
        end else begin
            if (state_nxt != state)
                timer <= '0;
            else if (state == CONV || state == POOL || state == FC)
                timer <= timer + TW'(1);
            if (state == IDLE && start) begin
                label_q  <= label;
                beat_cnt <= '0;
            end else if (beat_take) begin
                beat_cnt <= beat_cnt + KW'(1);
            end
            best_score <= best_score_nxt;
            best_idx   <= best_idx_nxt;
        end
    end

    // Registered outputs: start pulses on stage entry, result on FINISH/ERROR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_start     <= 1'b0;
            pool_start     <= 1'b0;
            fc_start       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            classification <= 4'h0;
            correct        <= 1'b0;
            err            <= 1'b0;
        end else begin
            conv_start <= (state_nxt == CONV) && (state != CONV);
            pool_start <= (state_nxt == POOL) && (state != POOL);
            fc_start   <= (state_nxt == FC)   && (state != FC);
            busy       <= (state_nxt != IDLE);
            done       <= (state_nxt == FINISH) || (state_nxt == ERROR);
            if (state == IDLE && start)
                err <= 1'b0;
            if (state_nxt == FINISH) begin
                classification <= best_idx_nxt;
                correct        <= (best_idx_nxt == label_q);
                err            <= 1'b0;
            end else if (state_nxt == ERROR) begin
                classification <= 4'hF;
                correct        <= 1'b0;
                err            <= 1'b1;
            end
        end
    end

endmodule
